// File: rtl/session_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : session_controller                                            |
// | Purpose  : Player session FSM with idle timeout and best-score update.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module session_controller #(
    parameter int TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       LoggedIn,
    input  logic       isGuest,
    input  logic [4:0] PlayerAddress,
    input  logic       StartButton,
    input  logic       LogoutButton,
    input  logic       GameOver,
    input  logic [7:0] Score,
    input  logic [7:0] BestRdData,
    output logic       LogoutCommand,
    output logic       GameEnable,
    output logic [4:0] BestAddr,
    output logic [7:0] BestWrData,
    output logic       BestWrEn,
    output logic       NewBest,
    output logic [2:0] State
);

    localparam int                CNT_W   = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READY   = 3'd1,
        PLAY    = 3'd2,
        CHECK   = 3'd3,
        SAVE    = 3'd4,
        LOGOUT  = 3'd5,
        WAITOUT = 3'd6
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] idle_cnt;
    logic [4:0]       addr;
    logic             guest;
    logic [7:0]       score_q;
    logic             wr_en;

    // Loss of login overrides every other transition in the active states.
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (LoggedIn) nxt = READY;
            end
            READY: begin
                if (!LoggedIn)                                 nxt = IDLE;
                else if (LogoutButton || idle_cnt == CNT_MAX)  nxt = LOGOUT;
                else if (StartButton)                          nxt = PLAY;
            end
            PLAY: begin
                if (!LoggedIn)          nxt = IDLE;
                else if (GameOver)      nxt = CHECK;
                else if (LogoutButton)  nxt = LOGOUT;
            end
            CHECK: begin
                if (!LoggedIn)                          nxt = IDLE;
                else if (!guest && score_q > BestRdData) nxt = SAVE;
                else                                    nxt = READY;
            end
            SAVE: begin
                nxt = LoggedIn ? READY : IDLE;
            end
            LOGOUT: begin
                nxt = WAITOUT;
            end
            WAITOUT: begin
                if (!LoggedIn) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            idle_cnt      <= '0;
            addr          <= '0;
            guest         <= 1'b0;
            score_q       <= '0;
            wr_en         <= 1'b0;
            GameEnable    <= 1'b0;
            LogoutCommand <= 1'b0;
            NewBest       <= 1'b0;
        end else begin
            state         <= nxt;
            GameEnable    <= (nxt == PLAY);
            LogoutCommand <= (nxt == LOGOUT);
            wr_en         <= (nxt == SAVE);

            if (state == IDLE && LoggedIn) begin
                addr  <= PlayerAddress;
                guest <= isGuest;
            end

            if (nxt == READY && state != READY)
                idle_cnt <= '0;
            else if (state == READY && idle_cnt != CNT_MAX)
                idle_cnt <= idle_cnt + CNT_W'(1);

            if (state == PLAY && LoggedIn && GameOver)
                score_q <= Score;

            if (state == READY && nxt == PLAY)
                NewBest <= 1'b0;
            if (nxt == SAVE)
                NewBest <= 1'b1;

            // Address survives logout so BestAddr stays stable until next login.
            if (nxt == IDLE && state != IDLE) begin
                guest   <= 1'b0;
                NewBest <= 1'b0;
            end
        end
    end

    // A SAVE cycle that loses login must not commit its write.
    assign BestWrEn   = wr_en & LoggedIn;
    assign BestWrData = score_q;
    assign BestAddr   = addr;
    assign State      = state;

endmodule
`default_nettype wire

// File: tb/tb_session_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_session_controller                                         |
// | Purpose  : Directed self-checking bench for session_controller.          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_session_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       LoggedIn;
    logic       isGuest;
    logic [4:0] PlayerAddress;
    logic       StartButton;
    logic       LogoutButton;
    logic       GameOver;
    logic [7:0] Score;
    logic [7:0] BestRdData;
    logic       LogoutCommand;
    logic       GameEnable;
    logic [4:0] BestAddr;
    logic [7:0] BestWrData;
    logic       BestWrEn;
    logic       NewBest;
    logic [2:0] State;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_READY = 3'd1, S_PLAY = 3'd2,
                           S_CHECK = 3'd3, S_SAVE = 3'd4, S_LOGOUT = 3'd5,
                           S_WAITOUT = 3'd6;

    session_controller #(.TIMEOUT(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .LoggedIn      (LoggedIn),
        .isGuest       (isGuest),
        .PlayerAddress (PlayerAddress),
        .StartButton   (StartButton),
        .LogoutButton  (LogoutButton),
        .GameOver      (GameOver),
        .Score         (Score),
        .BestRdData    (BestRdData),
        .LogoutCommand (LogoutCommand),
        .GameEnable    (GameEnable),
        .BestAddr      (BestAddr),
        .BestWrData    (BestWrData),
        .BestWrEn      (BestWrEn),
        .NewBest       (NewBest),
        .State         (State)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; LoggedIn = 1'b0; isGuest = 1'b0; PlayerAddress = 5'd0;
        StartButton = 1'b0; LogoutButton = 1'b0; GameOver = 1'b0;
        Score = 8'd0; BestRdData = 8'd0;

        #3;
        check("rst_state", State, S_IDLE);
        check("rst_game_en", GameEnable, 1'b0);
        check("rst_logout_cmd", LogoutCommand, 1'b0);
        check("rst_wr_en", BestWrEn, 1'b0);
        check("rst_wr_data", BestWrData, 8'd0);
        check("rst_addr", BestAddr, 5'd0);
        check("rst_newbest", NewBest, 1'b0);
        #5 rst = 1'b1;
        tick();
        check("idle_no_login", State, S_IDLE);

        // Non-guest record: 40 beats stored 30
        LoggedIn = 1'b1; isGuest = 1'b0; PlayerAddress = 5'd5;
        tick();
        check("login_ready", State, S_READY);
        check("login_addr", BestAddr, 5'd5);
        PlayerAddress = 5'd9;
        StartButton = 1'b1;
        tick();
        StartButton = 1'b0;
        check("start_play", State, S_PLAY);
        check("play_game_en", GameEnable, 1'b1);
        tick();
        check("play_addr_held", BestAddr, 5'd5);
        Score = 8'd40; BestRdData = 8'd30; GameOver = 1'b1;
        tick();
        GameOver = 1'b0;
        check("go_check", State, S_CHECK);
        check("check_game_en", GameEnable, 1'b0);
        tick();
        check("save_state", State, S_SAVE);
        check("save_wr_en", BestWrEn, 1'b1);
        check("save_wr_data", BestWrData, 8'd40);
        check("save_addr", BestAddr, 5'd5);
        check("save_newbest", NewBest, 1'b1);
        tick();
        check("save_ready", State, S_READY);
        check("after_save_wr_en", BestWrEn, 1'b0);
        check("after_save_newbest", NewBest, 1'b1);

        // Equal score is not a record
        StartButton = 1'b1;
        tick();
        StartButton = 1'b0;
        check("replay_newbest_clr", NewBest, 1'b0);
        Score = 8'd40; BestRdData = 8'd40; GameOver = 1'b1;
        tick();
        GameOver = 1'b0;
        check("eq_check", State, S_CHECK);
        tick();
        check("eq_ready", State, S_READY);
        check("eq_wr_en", BestWrEn, 1'b0);
        check("eq_newbest", NewBest, 1'b0);

        // Guest with a high score never saves
        LoggedIn = 1'b0;
        tick();
        check("ready_drop_idle", State, S_IDLE);
        LoggedIn = 1'b1; isGuest = 1'b1; PlayerAddress = 5'd3;
        tick();
        check("guest_addr", BestAddr, 5'd3);
        StartButton = 1'b1;
        tick();
        StartButton = 1'b0;
        Score = 8'd200; BestRdData = 8'd10; GameOver = 1'b1;
        tick();
        GameOver = 1'b0;
        check("guest_check", State, S_CHECK);
        check("guest_check_wr_en", BestWrEn, 1'b0);
        tick();
        check("guest_ready", State, S_READY);
        check("guest_wr_en", BestWrEn, 1'b0);
        check("guest_newbest", NewBest, 1'b0);

        // GameOver and LogoutButton together: GameOver wins
        StartButton = 1'b1;
        tick();
        StartButton = 1'b0;
        Score = 8'd5; GameOver = 1'b1; LogoutButton = 1'b1;
        tick();
        GameOver = 1'b0; LogoutButton = 1'b0;
        check("go_lo_check", State, S_CHECK);
        check("go_lo_no_cmd", LogoutCommand, 1'b0);
        tick();
        check("go_lo_ready", State, S_READY);

        // Login lost during PLAY
        StartButton = 1'b1;
        tick();
        StartButton = 1'b0;
        check("drop_play_pre", GameEnable, 1'b1);
        LoggedIn = 1'b0;
        tick();
        check("drop_play_idle", State, S_IDLE);
        check("drop_play_game_en", GameEnable, 1'b0);
        check("drop_play_addr_kept", BestAddr, 5'd3);

        // Login lost during SAVE suppresses the write
        LoggedIn = 1'b1; isGuest = 1'b0; PlayerAddress = 5'd7;
        tick();
        StartButton = 1'b1;
        tick();
        StartButton = 1'b0;
        Score = 8'd100; BestRdData = 8'd50; GameOver = 1'b1;
        tick();
        GameOver = 1'b0;
        tick();
        check("drop_save_state", State, S_SAVE);
        check("drop_save_wr_en_pre", BestWrEn, 1'b1);
        LoggedIn = 1'b0;
        #1;
        check("drop_save_wr_en", BestWrEn, 1'b0);
        tick();
        check("drop_save_idle", State, S_IDLE);
        check("drop_save_newbest", NewBest, 1'b0);
        check("drop_save_wr_en_post", BestWrEn, 1'b0);

        // Start and Logout together in READY: logout wins
        LoggedIn = 1'b1;
        tick();
        StartButton = 1'b1; LogoutButton = 1'b1;
        tick();
        StartButton = 1'b0; LogoutButton = 1'b0;
        check("st_lo_logout", State, S_LOGOUT);
        check("st_lo_cmd", LogoutCommand, 1'b1);
        check("st_lo_game_en", GameEnable, 1'b0);
        tick();
        check("st_lo_waitout", State, S_WAITOUT);
        check("st_lo_cmd_off", LogoutCommand, 1'b0);
        LoggedIn = 1'b0;
        tick();
        check("st_lo_idle", State, S_IDLE);

        // Idle timeout with TIMEOUT=8: logout on the 9th cycle after READY entry
        LoggedIn = 1'b1;
        tick();
        check("to_ready_c1", State, S_READY);
        for (int i = 2; i <= 8; i++) begin
            tick();
            check("to_ready_wait", {LogoutCommand, State}, {1'b0, S_READY});
        end
        tick();
        check("to_logout_state", State, S_LOGOUT);
        check("to_logout_cmd", LogoutCommand, 1'b1);
        StartButton = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_waitout_hold", {LogoutCommand, State}, {1'b0, S_WAITOUT});
        end
        StartButton = 1'b0;
        LoggedIn = 1'b0;
        tick();
        check("to_idle", State, S_IDLE);

        // Asynchronous reset mid-PLAY
        LoggedIn = 1'b1;
        tick();
        StartButton = 1'b1;
        tick();
        StartButton = 1'b0;
        check("arst_pre_play", State, S_PLAY);
        #2 rst = 1'b0;
        #1;
        check("arst_state", State, S_IDLE);
        check("arst_game_en", GameEnable, 1'b0);
        check("arst_addr", BestAddr, 5'd0);
        check("arst_wr_data", BestWrData, 8'd0);
        check("arst_wr_en", BestWrEn, 1'b0);
        tick();
        check("arst_held", State, S_IDLE);
        rst = 1'b1;
        tick();
        check("arst_release_ready", State, S_READY);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/session_controller.md
SESSION_CONTROLLER -- requirements
Module: session_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1000, meaning idle cycles allowed in READY before a forced logout (legal range 2..2^20).
REQ-002 SHALL have port clk  in  1  the single system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port LoggedIn  in  1  level from the authenticator, 1 while a player session is valid.
REQ-005 SHALL have port isGuest  in  1  guest flag from the authenticator, valid while LoggedIn=1.
REQ-006 SHALL have port PlayerAddress  in  5  player slot from the authenticator, valid while LoggedIn=1.
REQ-007 SHALL have ports StartButton, LogoutButton, GameOver  in  1 each  single-cycle pulses, already debounced and synchronized.
REQ-008 SHALL have port Score  in  8  final game score, valid in the cycle GameOver=1 and held until the next game starts.
REQ-009 SHALL have port BestRdData  in  8  best-score memory read data, combinational from BestAddr.
REQ-010 SHALL have port LogoutCommand  out  1  logout request pulse to the authenticator.
REQ-011 SHALL have port GameEnable  out  1  runs the game datapath.
REQ-012 SHALL have ports BestAddr  out  5, BestWrData  out  8, BestWrEn  out  1  best-score memory write port.
REQ-013 SHALL have ports NewBest  out  1 (last game set a record) and State  out  3 (current state code).

Function
REQ-014 SHALL implement states IDLE=0, READY=1, PLAY=2, CHECK=3, SAVE=4, LOGOUT=5, WAITOUT=6; code 7 SHALL transition to IDLE.
REQ-015 IDLE: on LoggedIn=1 SHALL latch PlayerAddress and isGuest into internal registers and go to READY next cycle.
REQ-016 BestAddr SHALL always equal the latched address; inputs PlayerAddress/isGuest SHALL be ignored outside IDLE.
REQ-017 READY: idle counter SHALL clear on every READY entry, increment each READY cycle, and on reaching TIMEOUT-1 go to LOGOUT.
REQ-018 READY: StartButton SHALL go to PLAY and clear NewBest; LogoutButton SHALL go to LOGOUT; both in the same cycle -> LOGOUT.
REQ-019 PLAY: GameEnable SHALL be 1 in every PLAY cycle and 0 in all other states (registered output, asserted the cycle State=2).
REQ-020 PLAY: GameOver SHALL capture Score into an 8-bit register and go to CHECK; LogoutButton SHALL go to LOGOUT with no save; both together -> CHECK (GameOver wins, logout pulse ignored).
REQ-021 CHECK (one cycle): guest -> READY; non-guest and captured score > BestRdData (unsigned, strict) -> SAVE; else -> READY.
REQ-022 SAVE (one cycle): BestWrEn=1, BestWrData=captured score, NewBest set to 1, then READY; BestWrEn SHALL be 0 in every other state.
REQ-023 LOGOUT (one cycle): LogoutCommand=1, then WAITOUT; LogoutCommand SHALL be 0 in every other state.
REQ-024 WAITOUT: SHALL stay until LoggedIn=0, then IDLE; no button is acted on.
REQ-025 In READY, PLAY, CHECK or SAVE, LoggedIn=0 SHALL force IDLE next cycle with priority over all other transitions; from SAVE the write in that cycle SHALL be suppressed (BestWrEn=0).
REQ-026 Entering IDLE SHALL clear NewBest and the latched guest flag; latched address SHALL be retained.
REQ-027 Idle counter SHALL saturate, never wrap, and be sized to hold TIMEOUT-1.

Reset
REQ-028 rst=0 SHALL immediately force State=IDLE, LogoutCommand=0, GameEnable=0, BestWrEn=0, BestWrData=0, BestAddr=0, NewBest=0, counter=0, captured score=0.
REQ-029 Reset asserted mid-game or mid-SAVE SHALL abort with no memory write; first transition out of reset occurs on the first clk edge after rst=1.

Verification
REQ-030 Login addr=5 non-guest, Start, GameOver Score=40, BestRdData=30 -> CHECK then one-cycle BestWrEn with BestAddr=5, BestWrData=40, NewBest=1, back to READY.
REQ-031 Same with BestRdData=40 (equal) and separately isGuest=1 with Score=200 -> no BestWrEn, NewBest=0, READY after CHECK.
REQ-032 TIMEOUT=8, login, no buttons -> LogoutCommand pulse 1 cycle on the 9th cycle after READY entry; hold LoggedIn=1 3 cycles -> WAITOUT held; drop LoggedIn -> IDLE.
REQ-033 PLAY with GameOver and LogoutButton same cycle -> CHECK, no LogoutCommand; READY with Start and LogoutButton same cycle -> LOGOUT, GameEnable stays 0.
REQ-034 LoggedIn dropped during PLAY and during SAVE -> IDLE next cycle, GameEnable=0, no BestWrEn; rst=0 asserted mid-PLAY -> all outputs at reset values without a clock edge.
